hot_cold_game: RTL and testbench

//  Sequential, parametrised hot/cold guessing-game core. Generates a secret from a seeded LFSR,

---
 rtl/hot_cold_pkg.sv | 31 +++
 rtl/hot_cold_game_lfsr.sv | 28 ++
 rtl/hot_cold_game.sv | 130 +++++++++++++
 tb/tb_hot_cold_game.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/hot_cold_pkg.sv
// rtl/hot_cold_pkg.sv - shared types, hint encodings and LFSR step for the hot/cold game
package hot_cold_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WON  = 2'd2,
    LOST = 2'd3
  } stateT;

  localparam logic [1:0] HL_NONE  = 2'b00;
  localparam logic [1:0] HL_LOW   = 2'b01;
  localparam logic [1:0] HL_HIGH  = 2'b10;
  localparam logic [1:0] HL_EQUAL = 2'b11;

  localparam logic [1:0] HC_NONE = 2'b00;
  localparam logic [1:0] HC_COLD = 2'b01;
  localparam logic [1:0] HC_WARM = 2'b10;
  localparam logic [1:0] HC_HOT  = 2'b11;

  // Shift left, feed the parity of the tapped bits into bit 0; result masked to width bits.
  function automatic logic [31:0] lfsrStep(input logic [31:0] s, input logic [31:0] taps,
                                           input int width);
    logic [31:0] mask;
    logic        fb;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    fb   = ^(s & taps & mask);
    return ((s << 1) | {31'd0, fb}) & mask;
  endfunction

endpackage

// File: rtl/hot_cold_game_lfsr.sv
// rtl/hot_cold_game_lfsr.sv - lfsr_gen: loads a seed and advances it one step to form the secret
module lfsr_gen
  import hot_cold_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'b1100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] secret
);

  logic [WIDTH-1:0] loadVal;

  // An all-zero LFSR would never leave zero, so a zero seed is forced to 1.
  assign loadVal = (seed == '0) ? WIDTH'(1) : seed;

  always_ff @(posedge clk) begin
    if (reset) begin
      secret <= '0;
    end else if (load) begin
      secret <= WIDTH'(lfsrStep(32'(loadVal), 32'(TAPS), WIDTH));
    end
  end

endmodule

// File: rtl/hot_cold_game.sv
// rtl/hot_cold_game.sv - hot/cold guessing-game core: button edges, game FSM and guess scoring
// Optional attempt limit and LOST state enabled by defining HCG_TRY_LIMIT_EN.
module hot_cold_game
  import hot_cold_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] TAPS        = 4'b1100,
  parameter int               WARM_THRESH = 4,
  parameter int               COLD_THRESH = 10,
  parameter int               MAX_TRIES   = 8,
`ifdef HCG_TRY_LIMIT_EN
  localparam int              TW          = $clog2(MAX_TRIES + 1)
`else
  localparam int              TW          = 8
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] guess,
  input  logic             new_btn,
  input  logic             sub_btn,
  output logic [1:0]       hi_low,
  output logic [1:0]       hot_cold,
  output logic [TW-1:0]    tries,
  output logic             won,
  output logic             lost,
  output logic             playing
);

  localparam logic [TW-1:0] TRY_MAX = '1;

  stateT            state, nextState;
  logic             newQ, subQ;
  logic             newEv, subEv;
  logic [WIDTH-1:0] secret;
  logic [WIDTH-1:0] diff;
  logic [1:0]       hlScore, hcScore;
  logic [1:0]       hiLowQ, hotColdQ;
  logic [TW-1:0]    triesQ;
  logic             limitHit;
  logic             scoreEv;

  // A simultaneous new-game press takes priority, so the submit is dropped.
  assign newEv   = new_btn & ~newQ;
  assign subEv   = sub_btn & ~subQ & ~newEv;
  assign scoreEv = subEv && (state == PLAY);

  lfsr_gen #(
    .WIDTH(WIDTH),
    .TAPS (TAPS)
  ) uLfsr (
    .clk   (clk),
    .reset (reset),
    .load  (newEv),
    .seed  (seed),
    .secret(secret)
  );

  always_comb begin
    diff    = (guess >= secret) ? (guess - secret) : (secret - guess);
    hlScore = HL_HIGH;
    if (guess == secret) hlScore = HL_EQUAL;
    else if (guess < secret) hlScore = HL_LOW;
    hcScore = HC_COLD;
    if (int'(diff) < WARM_THRESH) hcScore = HC_HOT;
    else if (int'(diff) < COLD_THRESH) hcScore = HC_WARM;
  end

`ifdef HCG_TRY_LIMIT_EN
  assign limitHit = (int'(triesQ) + 1 == MAX_TRIES);
`else
  assign limitHit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    if (newEv) begin
      nextState = PLAY;
    end else if (scoreEv) begin
      if (guess == secret) nextState = WON;
      else if (limitHit) nextState = LOST;
    end
  end

  always_comb begin
    playing = (state == PLAY);
    won     = (state == WON);
`ifdef HCG_TRY_LIMIT_EN
    lost    = (state == LOST);
`else
    lost    = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      newQ     <= 1'b0;
      subQ     <= 1'b0;
      hiLowQ   <= HL_NONE;
      hotColdQ <= HC_NONE;
      triesQ   <= '0;
    end else begin
      newQ <= new_btn;
      subQ <= sub_btn;
      if (newEv) begin
        hiLowQ   <= HL_NONE;
        hotColdQ <= HC_NONE;
        triesQ   <= '0;
      end else if (scoreEv) begin
        hiLowQ   <= hlScore;
        hotColdQ <= (hlScore == HL_EQUAL) ? HC_HOT : hcScore;
        triesQ   <= (triesQ == TRY_MAX) ? triesQ : triesQ + TW'(1);
      end
    end
  end

  assign hi_low   = hiLowQ;
  assign hot_cold = hotColdQ;
  assign tries    = triesQ;

endmodule

// File: tb/tb_hot_cold_game.sv
// tb/tb_hot_cold_game.sv - directed table-driven bench for hot_cold_game
module tb_hot_cold_game;

`ifdef HCG_TRY_LIMIT_EN
  localparam int TWA = 4;
  localparam int TWB = 2;
  localparam logic LIMIT_ON = 1'b1;
`else
  localparam int TWA = 8;
  localparam int TWB = 8;
  localparam logic LIMIT_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [3:0]     seed = '0;
  logic [3:0]     guess = '0;
  logic           new_btn = 1'b0;
  logic           sub_btn = 1'b0;
  logic [1:0]     hiLowA, hotColdA, hiLowB, hotColdB;
  logic [TWA-1:0] triesA;
  logic [TWB-1:0] triesB;
  logic           wonA, lostA, playingA, wonB, lostB, playingB;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hot_cold_game dutA (
    .clk(clk), .reset(reset), .seed(seed), .guess(guess),
    .new_btn(new_btn), .sub_btn(sub_btn),
    .hi_low(hiLowA), .hot_cold(hotColdA), .tries(triesA),
    .won(wonA), .lost(lostA), .playing(playingA)
  );

  hot_cold_game #(.MAX_TRIES(3)) dutB (
    .clk(clk), .reset(reset), .seed(seed), .guess(guess),
    .new_btn(new_btn), .sub_btn(sub_btn),
    .hi_low(hiLowB), .hot_cold(hotColdB), .tries(triesB),
    .won(wonB), .lost(lostB), .playing(playingB)
  );

  typedef struct {
    logic       newGame;
    logic [3:0] seed;
    logic [3:0] guess;
    logic [1:0] hl;
    logic [1:0] hc;
    int         tries;
    logic       won;
  } vecT;

  vecT vecs[8];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startGame(input logic [3:0] s);
    seed = s;
    new_btn = 1'b1;
    tick();
    new_btn = 1'b0;
    tick();
  endtask

  task automatic pressSub(input logic [3:0] g);
    guess = g;
    sub_btn = 1'b1;
    tick();
    sub_btn = 1'b0;
    tick();
  endtask

  initial begin
    // secret 0101 from seed 1010
    vecs[0] = '{1'b1, 4'b1010, 4'b1111, 2'b10, 2'b01, 1, 1'b0};
    vecs[1] = '{1'b0, 4'b1010, 4'b1110, 2'b10, 2'b10, 2, 1'b0};
    vecs[2] = '{1'b0, 4'b1010, 4'b1000, 2'b10, 2'b11, 3, 1'b0};
    vecs[3] = '{1'b0, 4'b1010, 4'b0101, 2'b11, 2'b11, 4, 1'b1};
    vecs[4] = '{1'b0, 4'b1010, 4'b0000, 2'b11, 2'b11, 4, 1'b1};
    vecs[5] = '{1'b1, 4'b1010, 4'b1001, 2'b10, 2'b10, 1, 1'b0};
    vecs[6] = '{1'b0, 4'b1010, 4'b0001, 2'b01, 2'b10, 2, 1'b0};
    vecs[7] = '{1'b0, 4'b1010, 4'b0010, 2'b01, 2'b11, 3, 1'b0};

    // T1 reset
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_hl", int'(hiLowA), 0);
    check("rst_hc", int'(hotColdA), 0);
    check("rst_tries", int'(triesA), 0);
    check("rst_flags", int'({wonA, lostA, playingA}), 0);

    // T2/T3 and threshold boundaries
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].newGame) begin
        startGame(vecs[i].seed);
        check($sformatf("v%0d_play", i), int'(playingA), 1);
        check($sformatf("v%0d_clr", i), int'(triesA), 0);
      end
      pressSub(vecs[i].guess);
      check($sformatf("v%0d_hl", i), int'(hiLowA), int'(vecs[i].hl));
      check($sformatf("v%0d_hc", i), int'(hotColdA), int'(vecs[i].hc));
      check($sformatf("v%0d_tries", i), int'(triesA), vecs[i].tries);
      check($sformatf("v%0d_won", i), int'(wonA), int'(vecs[i].won));
    end

    // T4 attempt limit on the MAX_TRIES=3 instance, secret 1110
    startGame(4'b1111);
    for (int k = 1; k <= 3; k++) begin
      pressSub(4'b0000);
      check($sformatf("t4_hl%0d", k), int'(hiLowB), 1);
      check($sformatf("t4_hc%0d", k), int'(hotColdB), 1);
      check($sformatf("t4_tries%0d", k), int'(triesB), k);
    end
    check("t4_lost", int'(lostB), int'(LIMIT_ON));
    check("t4_play", int'(playingB), int'(!LIMIT_ON));
    pressSub(4'b0000);
    check("t4_after", int'(triesB), LIMIT_ON ? 3 : 4);

    // T5 held submit, then simultaneous new+submit
    startGame(4'b1010);
    guess = 4'b0000;
    sub_btn = 1'b1;
    repeat (10) tick();
    sub_btn = 1'b0;
    tick();
    check("t5_held", int'(triesA), 1);
    new_btn = 1'b1;
    sub_btn = 1'b1;
    tick();
    new_btn = 1'b0;
    sub_btn = 1'b0;
    check("t5_both_play", int'(playingA), 1);
    check("t5_both_tries", int'(triesA), 0);
    check("t5_both_hl", int'(hiLowA), 0);
    tick();

    // T6 zero seed -> secret 0010, then reset mid-game
    startGame(4'b0000);
    pressSub(4'b0010);
    check("t6_eq_hl", int'(hiLowA), 3);
    check("t6_eq_won", int'(wonA), 1);
    startGame(4'b0000);
    pressSub(4'b0011);
    check("t6_pre_hl", int'(hiLowA), 2);
    check("t6_pre_play", int'(playingA), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_hl", int'(hiLowA), 0);
    check("t6_rst_hc", int'(hotColdA), 0);
    check("t6_rst_tries", int'(triesA), 0);
    check("t6_rst_flags", int'({wonA, lostA, playingA}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
